round_sequencer: RTL
====================

// Module: round_sequencer
// PURPOSE
//   Match/round controller for the two-player bomb game. Sits between the hit-box controller
//   (a_win/b_win) and the player, pixel and hit-box blocks. Sequences IDLE -> countdown -> play
//   -> intermission -> match end. Gates player key commands with play_en and holds the
//   game-state blocks in reset with round_rst. Keeps the saturating per-player win counts shown
//   on the seven-segment display.
// PARAMETERS
//   TICK_CYCLES      100_000_000  clk cycles per countdown/intermission tick (1 s at 100 MHz)
//   COUNTDOWN_TICKS  3            ticks shown before each round (1..15)
//   ROUND_END_TICKS  2            intermission ticks after a round (>=1)
//   WIN_TARGET       4            round wins that end the match (1..15)
// PORTS
//   clk          in   1  system clock
//   rst          in   1  asynchronous, active-low reset
//   start        in   1  one-cycle pulse (Enter key): begins a match from IDLE or MATCH_END
//   abort        in   1  one-cycle pulse: returns to IDLE from any state
//   a_win        in   1  level from hit-box controller: player A won the round
//   b_win        in   1  level from hit-box controller: player B won the round
//   play_en      out  1  1 = player/attack commands are accepted
//   round_rst    out  1  1 = hold players, map and hit-box in their reset state
//   countdown    out  4  remaining countdown ticks, for the SSD; 0 outside COUNTDOWN
//   num_a_win    out  4  rounds won by A in the current match
//   num_b_win    out  4  rounds won by B in the current match
//   match_over   out  1  1 while in MATCH_END
//   match_winner out  1  0 = A, 1 = B; valid while match_over = 1
//   state        out  3  IDLE=0, COUNTDOWN=1, PLAY=2, ROUND_END=3, MATCH_END=4
// BEHAVIOUR
//   - All outputs are registered. While rst = 0 the block is held in its reset state:
//     state=IDLE, tick counter=0, countdown=0, num_a_win=0, num_b_win=0, play_en=0,
//     round_rst=1, match_over=0, match_winner=0.
//   - Tick counter: runs only in COUNTDOWN and ROUND_END and is cleared to 0 on entry to any
//     state. tick = (counter == TICK_CYCLES-1). The counter wraps to 0 on each tick.
//   - Any state, abort=1 -> IDLE next cycle. Scores and countdown are cleared. abort has
//     priority over every other input.
//   - IDLE: play_en=0, round_rst=1.
//       start -> COUNTDOWN: countdown=COUNTDOWN_TICKS, scores=0.
//   - COUNTDOWN: play_en=0, round_rst=1. Each tick decrements countdown.
//       Tick while countdown==1 -> PLAY with countdown=0.
//       Duration is COUNTDOWN_TICKS*TICK_CYCLES cycles.
//   - PLAY: play_en=1, round_rst=0. a_win and b_win are sampled only in this state.
//       a_win=1 and b_win=1 in the same cycle: draw. No score change -> ROUND_END.
//       Only a_win=1: num_a_win+1. If the new value == WIN_TARGET -> MATCH_END with
//       match_winner=0; else -> ROUND_END. B is symmetric, with match_winner=1.
//       Exactly one increment per round, however long the win level is held.
//       Latency: win sampled in cycle N -> score, state, play_en=0 and round_rst=1 in cycle N+1.
//   - ROUND_END: play_en=0, round_rst=1. After ROUND_END_TICKS ticks -> COUNTDOWN with
//     countdown=COUNTDOWN_TICKS. Scores are held.
//   - MATCH_END: play_en=0, round_rst=1, match_over=1. Scores and winner are held.
//       start -> COUNTDOWN with scores cleared to 0 and match_over=0.
//   - start is ignored in COUNTDOWN, PLAY and ROUND_END.
//     a_win/b_win are ignored outside PLAY.
//   - Scores are 4 bits and never exceed WIN_TARGET, so no wrap is possible.
//   - If rst is asserted mid-round, every output takes its reset value immediately,
//     asynchronously.
// TESTING (TICK_CYCLES=4, COUNTDOWN_TICKS=3, ROUND_END_TICKS=2, WIN_TARGET=2)
//   1. Release rst, pulse start -> countdown=3, then 2 and 1 at 4-cycle steps. play_en=1 and
//      round_rst=0 exactly 12 cycles after COUNTDOWN entry.
//   2. In PLAY, hold a_win for 5 cycles -> num_a_win=1 (once), state=3 next cycle.
//      After 8 cycles state=1 and countdown=3.
//   3. In PLAY, assert a_win and b_win in the same cycle -> scores stay 0/0, state=3.
//   4. B wins two rounds -> num_b_win=2, state=4, match_over=1, match_winner=1.
//      Then start -> scores 0/0, state=1, match_over=0.
//   5. start pulse in PLAY -> no change. abort in COUNTDOWN -> state=0, countdown=0.
//      a_win in IDLE/COUNTDOWN -> scores unchanged.
//   6. Drive rst=0 mid-PLAY with num_a_win=1 -> all outputs at reset values with no clock
//      edge. After release, state=0.

Source files
------------

// File: rtl/round_sequencer.sv
// round_sequencer: match/round controller for the two-player bomb game.
// Walks IDLE -> countdown -> play -> intermission -> match end and keeps the per-player scores.
module round_sequencer #(
   parameter int TICK_CYCLES     = 100_000_000,
   parameter int COUNTDOWN_TICKS = 3,
   parameter int ROUND_END_TICKS = 2,
   parameter int WIN_TARGET      = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       a_win,
   input  logic       b_win,
   output logic       play_en,
   output logic       round_rst,
   output logic [3:0] countdown,
   output logic [3:0] num_a_win,
   output logic [3:0] num_b_win,
   output logic       match_over,
   output logic       match_winner,
   output logic [2:0] state
);
   localparam int CW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
   localparam int RW = ROUND_END_TICKS > 1 ? $clog2(ROUND_END_TICKS) : 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COUNTDOWN = 3'd1,
      PLAY      = 3'd2,
      ROUND_END = 3'd3,
      MATCH_END = 3'd4
   } state_t;

   state_t st;
   logic [CW-1:0] tickCnt;
   logic [RW-1:0] endTicks;
   logic tick;
   logic [3:0] nextA, nextB;

   assign state = st;
   assign tick  = tickCnt == CW'(TICK_CYCLES - 1);
   assign nextA = num_a_win + 4'd1;
   assign nextB = num_b_win + 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st           <= IDLE;
         tickCnt      <= '0;
         endTicks     <= '0;
         countdown    <= '0;
         num_a_win    <= '0;
         num_b_win    <= '0;
         play_en      <= 1'b0;
         round_rst    <= 1'b1;
         match_over   <= 1'b0;
         match_winner <= 1'b0;
      end else if (abort) begin
         st         <= IDLE;
         tickCnt    <= '0;
         endTicks   <= '0;
         countdown  <= '0;
         num_a_win  <= '0;
         num_b_win  <= '0;
         play_en    <= 1'b0;
         round_rst  <= 1'b1;
         match_over <= 1'b0;
      end else begin
         case (st)
            IDLE, MATCH_END: if (start) begin
               st         <= COUNTDOWN;
               tickCnt    <= '0;
               countdown  <= 4'(COUNTDOWN_TICKS);
               num_a_win  <= '0;
               num_b_win  <= '0;
               match_over <= 1'b0;
            end
            COUNTDOWN: begin
               tickCnt <= tick ? '0 : tickCnt + 1'b1;
               if (tick) begin
                  countdown <= countdown - 4'd1;
                  if (countdown == 4'd1) begin
                     st        <= PLAY;
                     tickCnt   <= '0;
                     play_en   <= 1'b1;
                     round_rst <= 1'b0;
                  end
               end
            end
            PLAY: if (a_win || b_win) begin
               // A tie counts for nobody; a single winner may close out the match.
               play_en   <= 1'b0;
               round_rst <= 1'b1;
               tickCnt   <= '0;
               endTicks  <= '0;
               st        <= ROUND_END;
               if (a_win && !b_win) begin
                  num_a_win <= nextA;
                  if (nextA == 4'(WIN_TARGET)) begin
                     st           <= MATCH_END;
                     match_over   <= 1'b1;
                     match_winner <= 1'b0;
                  end
               end else if (b_win && !a_win) begin
                  num_b_win <= nextB;
                  if (nextB == 4'(WIN_TARGET)) begin
                     st           <= MATCH_END;
                     match_over   <= 1'b1;
                     match_winner <= 1'b1;
                  end
               end
            end
            ROUND_END: begin
               tickCnt <= tick ? '0 : tickCnt + 1'b1;
               if (tick) begin
                  endTicks <= endTicks + 1'b1;
                  if (endTicks == RW'(ROUND_END_TICKS - 1)) begin
                     st        <= COUNTDOWN;
                     tickCnt   <= '0;
                     endTicks  <= '0;
                     countdown <= 4'(COUNTDOWN_TICKS);
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule
